// File: rtl/servo_angle_ramp.sv
// Servo angle ramp: moves dutty one degree every STEP_CYCLES clocks toward an accepted target.
// Optional macro SERVO_RAMP_CLAMP_EN saturates out-of-range targets instead of rejecting them.
module servo_angle_ramp #(
  parameter int unsigned STEP_CYCLES = 100000,
  parameter int unsigned MAX_ANGLE   = 180,
  parameter int unsigned RESET_ANGLE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] target,
  input  logic       target_valid,
  output logic       target_ready,
  output logic [7:0] dutty,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TW-1:0] TimerLast = TW'(STEP_CYCLES - 1);
  localparam logic [7:0] MaxAngle = 8'(MAX_ANGLE);
  localparam logic [7:0] RstAngle = 8'(RESET_ANGLE);

  typedef enum logic [1:0] {StIdle, StRamp, StDone} state_e;

  state_e        state_q, state_d;
  logic [7:0]    goal_q, goal_d;
  logic [7:0]    dutty_q, dutty_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ready_q, busy_q, done_q, err_q;
  logic          err_d;
  logic          xfer;
  logic          in_range;
  logic [7:0]    tgt_eff;
  logic [7:0]    goal_n;

`ifdef SERVO_RAMP_CLAMP_EN
  assign tgt_eff  = (target > MaxAngle) ? MaxAngle : target;
  assign in_range = 1'b1;
`else
  assign tgt_eff  = target;
  assign in_range = (target <= MaxAngle);
`endif

  assign xfer = target_valid && ready_q;

  always_comb begin
    state_d = state_q;
    goal_d  = goal_q;
    dutty_d = dutty_q;
    timer_d = timer_q;
    err_d   = 1'b0;
    goal_n  = goal_q;
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (xfer) begin
          if (!in_range) begin
            err_d = 1'b1;
          end else begin
            goal_d  = tgt_eff;
            state_d = (tgt_eff == dutty_q) ? StDone : StRamp;
          end
        end
      end
      StRamp: begin
        // A retarget replaces the goal but keeps the step phase running.
        if (xfer) begin
          if (!in_range) err_d = 1'b1;
          else           goal_n = tgt_eff;
        end
        goal_d = goal_n;
        if (goal_n == dutty_q) begin
          state_d = StDone;
          timer_d = '0;
        end else if (timer_q == TimerLast) begin
          timer_d = '0;
          dutty_d = (goal_n > dutty_q) ? dutty_q + 8'd1 : dutty_q - 8'd1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        timer_d = '0;
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      goal_q  <= RstAngle;
      dutty_q <= RstAngle;
      timer_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      goal_q  <= goal_d;
      dutty_q <= dutty_d;
      timer_q <= timer_d;
      ready_q <= (state_d != StDone);
      busy_q  <= (state_d == StRamp);
      done_q  <= (state_d == StDone);
      err_q   <= err_d;
    end
  end

  assign target_ready = ready_q;
  assign dutty        = dutty_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_servo_angle_ramp.sv
// Directed bench for servo_angle_ramp (STEP_CYCLES=4, MAX_ANGLE=180, RESET_ANGLE=0, reject build).
module tb_servo_angle_ramp;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] target = '0;
  logic       target_valid = 1'b0;
  logic       target_ready;
  logic [7:0] dutty;
  logic       busy, done, err;

  int tests = 0;
  int fails = 0;

  servo_angle_ramp #(
    .STEP_CYCLES(4),
    .MAX_ANGLE  (180),
    .RESET_ANGLE(0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .target      (target),
    .target_valid(target_valid),
    .target_ready(target_ready),
    .dutty       (dutty),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         v;
    logic [7:0] t;
    logic [7:0] d;
    bit         b;
    bit         dn;
    bit         r;
    bit         e;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit v, logic [7:0] t, logic [7:0] d, bit b, bit dn, bit r, bit e);
    vec_t x;
    x.v = v; x.t = t; x.d = d; x.b = b; x.dn = dn; x.r = r; x.e = e;
    vecs.push_back(x);
  endfunction

  // n idle-input cycles while ramping at angle d
  function automatic void ramp(int n, logic [7:0] d);
    for (int i = 0; i < n; i++) add(0, 8'd0, d, 1, 0, 1, 0);
  endfunction

  function automatic void fin(logic [7:0] d);
    add(0, 8'd0, d, 0, 1, 0, 0);
    add(0, 8'd0, d, 0, 0, 1, 0);
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(string tag, logic [7:0] d, bit b, bit dn, bit r, bit e);
    check({tag, " dutty"}, dutty, d);
    check({tag, " busy"}, {7'd0, busy}, {7'd0, b});
    check({tag, " done"}, {7'd0, done}, {7'd0, dn});
    check({tag, " ready"}, {7'd0, target_ready}, {7'd0, r});
    check({tag, " err"}, {7'd0, err}, {7'd0, e});
  endtask

  task automatic cycle(bit v, logic [7:0] t);
    @(negedge clk);
    target_valid = v;
    target       = t;
    @(posedge clk);
    #1;
  endtask

  int n;
  bit seen_done;

  initial begin
    // ramp up 0 -> 3
    add(1, 8'd3, 8'd0, 1, 0, 1, 0);
    ramp(3, 0); ramp(4, 1); ramp(4, 2); ramp(1, 3); fin(3);
    // ramp down 3 -> 1
    add(1, 8'd1, 8'd3, 1, 0, 1, 0);
    ramp(3, 3); ramp(4, 2); ramp(1, 1); fin(1);
    // no-op transfer at current angle
    add(1, 8'd1, 8'd1, 0, 1, 0, 0);
    add(0, 8'd0, 8'd1, 0, 0, 1, 0);
    // back to 0
    add(1, 8'd0, 8'd1, 1, 0, 1, 0);
    ramp(3, 1); ramp(1, 0); fin(0);
    // retarget 10 -> 0 at +5
    add(1, 8'd10, 8'd0, 1, 0, 1, 0);
    ramp(3, 0); ramp(1, 1);
    add(1, 8'd0, 8'd1, 1, 0, 1, 0);
    ramp(2, 1); ramp(1, 0); fin(0);
    // out-of-range target rejected
    add(1, 8'd200, 8'd0, 0, 0, 1, 1);
    add(0, 8'd0, 8'd0, 0, 0, 1, 0);

    // reset state
    #12;
    check_all("reset", 8'd0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("post-reset", 8'd0, 0, 0, 1, 0);

    foreach (vecs[i]) begin
      cycle(vecs[i].v, vecs[i].t);
      check_all($sformatf("vec%0d", i), vecs[i].d, vecs[i].b, vecs[i].dn, vecs[i].r, vecs[i].e);
    end

    // boundary: full-scale ramp to MAX_ANGLE
    cycle(1, 8'd180);
    n = 0;
    target_valid = 1'b0;
    while (n < 800 && !done) begin
      @(posedge clk); #1;
      n++;
    end
    check("max ramp cycles", 8'(n / 4), 8'(721 / 4));
    check("max ramp cycles mod", 8'(n % 4), 8'(721 % 4));
    check("max ramp dutty", dutty, 8'd180);
    cycle(0, 8'd0);
    // just above MAX_ANGLE from 180: rejected, dutty held
    cycle(1, 8'd181);
    check_all("tgt181", 8'd180, 0, 0, 1, 1);
    cycle(0, 8'd0);
    check_all("tgt181 after", 8'd180, 0, 0, 1, 0);

    // reset mid-ramp
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    cycle(0, 8'd0);
    cycle(1, 8'd9);
    target_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
    end
    check_all("pre-rst ramp", 8'd5, 1, 0, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    check_all("async rst", 8'd0, 0, 0, 0, 0);
    seen_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1;
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    if (done) seen_done = 1;
    check_all("rst release", 8'd0, 0, 0, 1, 0);
    check("no done after rst", {7'd0, seen_done}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
